// File: rtl/mem_pkg.sv
// Memory request/response payload types, shared by the router and the prioritized arbiter.
package mem_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

endpackage

// File: rtl/mem_router_if.sv
// Bundle of the router's decoupled channels: one core-side request/response pair plus CNT slave-side pairs.
interface mem_router_if #(
    parameter int CNT = 2
) ();
    import mem_pkg::*;

    logic      master_req_valid;
    logic      master_req_ready;
    mem_req_t  master_req_data;

    logic      master_resp_valid;
    logic      master_resp_ready;
    mem_resp_t master_resp_data;

    logic [CNT-1:0] slave_req_valid;
    logic [CNT-1:0] slave_req_ready;
    mem_req_t       slave_req_data [CNT];

    logic [CNT-1:0] slave_resp_valid;
    logic [CNT-1:0] slave_resp_ready;
    mem_resp_t      slave_resp_data [CNT];

    // The environment: drives core requests and plays the memory slaves.
    modport master (
        output master_req_valid, master_req_data, master_resp_ready,
        input  master_req_ready, master_resp_valid, master_resp_data,
        input  slave_req_valid, slave_req_data, slave_resp_ready,
        output slave_req_ready, slave_resp_valid, slave_resp_data
    );

    // The router: slave to the core, master to the memory slaves.
    modport slave (
        input  master_req_valid, master_req_data, master_resp_ready,
        output master_req_ready, master_resp_valid, master_resp_data,
        output slave_req_valid, slave_req_data, slave_resp_ready,
        input  slave_req_ready, slave_resp_valid, slave_resp_data
    );

endinterface

// File: rtl/mem_router_idx_fifo.sv
// Small synchronous FIFO of route indices with wrap-bit pointers; contents are intentionally not reset.
module idx_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Full when the indices match but the wrap bits differ.
    assign head  = mem[rd_ptr[AW-1:0]];
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/mem_router.sv
// One-to-many memory router: address-decodes each request to a slave and returns responses in request order.
module mem_router
    import mem_pkg::*;
#(
    parameter int          CNT         = 2,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] BASE [CNT]  = '{32'h0000_0000, 32'h1000_0000},
    parameter logic [31:0] MASK [CNT]  = '{32'hF000_0000, 32'hF000_0000}
) (
    input logic         clk,
    input logic         rst_n,
    mem_router_if.slave bus
);
    typedef logic [$clog2(CNT+1)-1:0] route_idx;
    localparam route_idx ERR = route_idx'(CNT);

    route_idx dest;
    route_idx head;
    logic     q_full;
    logic     q_empty;
    logic     push;
    logic     pop;

    // Lowest matching slave wins, so scan downward and let lower indices overwrite.
    always_comb begin
        dest = ERR;
        for (int i = CNT - 1; i >= 0; i--) begin
            if ((bus.master_req_data.addr & MASK[i]) == BASE[i]) dest = route_idx'(i);
        end
    end

    always_comb begin
        bus.master_req_ready = 1'b0;
        bus.slave_req_valid  = '0;
        for (int i = 0; i < CNT; i++) bus.slave_req_data[i] = bus.master_req_data;
        if (!q_full) begin
            if (dest == ERR) begin
                bus.master_req_ready = 1'b1;
            end else begin
                for (int i = 0; i < CNT; i++) begin
                    if (dest == route_idx'(i)) begin
                        bus.slave_req_valid[i] = bus.master_req_valid;
                        bus.master_req_ready   = bus.slave_req_ready[i];
                    end
                end
            end
        end
    end

    assign push = bus.master_req_valid && bus.master_req_ready;

    // Only the slave at the queue head may hand over a response; others are held off.
    always_comb begin
        bus.master_resp_valid = 1'b0;
        bus.master_resp_data  = '0;
        bus.slave_resp_ready  = '0;
        if (!q_empty) begin
            if (head == ERR) begin
                bus.master_resp_valid      = 1'b1;
                bus.master_resp_data.rdata = '0;
                bus.master_resp_data.err   = 1'b1;
            end else begin
                for (int i = 0; i < CNT; i++) begin
                    if (head == route_idx'(i)) begin
                        bus.master_resp_valid   = bus.slave_resp_valid[i];
                        bus.master_resp_data    = bus.slave_resp_data[i];
                        bus.slave_resp_ready[i] = bus.master_resp_ready;
                    end
                end
            end
        end
    end

    assign pop = bus.master_resp_valid && bus.master_resp_ready;

    idx_fifo #(
        .WIDTH ($bits(route_idx)),
        .DEPTH (QUEUE_DEPTH)
    ) u_route_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (dest),
        .pop       (pop),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: routing, ordering, error responses, queue full, backpressure and reset.
module tb_mem_router;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    mem_router_if #(.CNT(2)) bus ();

    mem_router #(.CNT(2), .QUEUE_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input logic valid, input logic [31:0] addr);
        bus.master_req_valid = valid;
        bus.master_req_data  = '{addr: addr, wdata: 32'h0, we: 1'b0, be: 4'hF};
    endtask

    initial begin
        rst_n                 = 1'b0;
        bus.master_resp_ready = 1'b0;
        bus.slave_req_ready   = 2'b01;
        bus.slave_resp_valid  = 2'b00;
        bus.slave_resp_data[0] = '0;
        bus.slave_resp_data[1] = '0;
        drive_req(1'b0, 32'h0);
        #1;
        check_output("rst_req_ready", 128'(bus.master_req_ready), 128'(1'b1));
        check_output("rst_slv_valid", 128'(bus.slave_req_valid), 128'(2'b00));
        check_output("rst_resp_valid", 128'(bus.master_resp_valid), 128'(1'b0));
        check_output("rst_slv_ready", 128'(bus.slave_resp_ready), 128'(2'b00));
        step();
        step();
        rst_n = 1'b1;

        $display("[TB] single route");
        step();
        drive_req(1'b1, 32'h1000_0040);
        bus.slave_req_ready = 2'b10;
        #1;
        check_output("sr_slv_valid", 128'(bus.slave_req_valid), 128'(2'b10));
        check_output("sr_req_ready", 128'(bus.master_req_ready), 128'(1'b1));
        check_output("sr_slv_addr", 128'(bus.slave_req_data[1].addr), 128'(32'h1000_0040));
        check_output("sr_resp_early", 128'(bus.master_resp_valid), 128'(1'b0));
        step();
        drive_req(1'b0, 32'h0);
        bus.slave_req_ready   = 2'b00;
        bus.master_resp_ready = 1'b1;
        #1;
        check_output("sr_wait_valid", 128'(bus.master_resp_valid), 128'(1'b0));
        check_output("sr_wait_ready", 128'(bus.slave_resp_ready), 128'(2'b10));
        step();
        bus.slave_resp_valid   = 2'b11;
        bus.slave_resp_data[0] = '{rdata: 32'h5555_5555, err: 1'b1};
        bus.slave_resp_data[1] = '{rdata: 32'hDEAD_BEEF, err: 1'b0};
        #1;
        check_output("sr_resp_valid", 128'(bus.master_resp_valid), 128'(1'b1));
        check_output("sr_resp_data", 128'(bus.master_resp_data), 128'({32'hDEAD_BEEF, 1'b0}));
        check_output("sr_slv_ready", 128'(bus.slave_resp_ready), 128'(2'b10));
        step();
        bus.slave_resp_valid = 2'b00;
        #1;
        check_output("sr_drained", 128'(bus.master_resp_valid), 128'(1'b0));
        check_output("sr_empty_ready", 128'(bus.slave_resp_ready), 128'(2'b00));

        $display("[TB] order enforcement");
        step();
        bus.master_resp_ready = 1'b0;
        bus.slave_req_ready   = 2'b11;
        drive_req(1'b1, 32'h0000_0000);
        #1;
        check_output("ord_req0", 128'(bus.slave_req_valid), 128'(2'b01));
        step();
        drive_req(1'b1, 32'h1000_0000);
        bus.slave_resp_valid   = 2'b10;
        bus.slave_resp_data[1] = '{rdata: 32'h1111_1111, err: 1'b0};
        #1;
        check_output("ord_req1", 128'(bus.slave_req_valid), 128'(2'b10));
        check_output("ord_early_ready", 128'(bus.slave_resp_ready), 128'(2'b00));
        step();
        drive_req(1'b0, 32'h0);
        bus.master_resp_ready = 1'b1;
        #1;
        check_output("ord_hold_ready", 128'(bus.slave_resp_ready), 128'(2'b01));
        check_output("ord_hold_valid", 128'(bus.master_resp_valid), 128'(1'b0));
        step();
        bus.slave_resp_valid   = 2'b11;
        bus.slave_resp_data[0] = '{rdata: 32'h0000_AAAA, err: 1'b0};
        #1;
        check_output("ord_first_data", 128'(bus.master_resp_data), 128'({32'h0000_AAAA, 1'b0}));
        check_output("ord_first_ready", 128'(bus.slave_resp_ready), 128'(2'b01));
        step();
        bus.slave_resp_valid = 2'b10;
        #1;
        check_output("ord_second_valid", 128'(bus.master_resp_valid), 128'(1'b1));
        check_output("ord_second_data", 128'(bus.master_resp_data), 128'({32'h1111_1111, 1'b0}));
        check_output("ord_second_ready", 128'(bus.slave_resp_ready), 128'(2'b10));
        step();
        bus.slave_resp_valid  = 2'b00;
        bus.master_resp_ready = 1'b0;
        #1;
        check_output("ord_drained", 128'(bus.master_resp_valid), 128'(1'b0));

        $display("[TB] unmapped address");
        step();
        drive_req(1'b1, 32'h2000_0000);
        #1;
        check_output("err_req_ready", 128'(bus.master_req_ready), 128'(1'b1));
        check_output("err_slv_valid", 128'(bus.slave_req_valid), 128'(2'b00));
        step();
        drive_req(1'b0, 32'h0);
        #1;
        check_output("err_resp_data", 128'(bus.master_resp_data), 128'({32'h0, 1'b1}));
        for (int i = 0; i < 3; i++) begin
            check_output("err_resp_held", 128'(bus.master_resp_valid), 128'(1'b1));
            step();
            #1;
        end
        bus.master_resp_ready = 1'b1;
        #1;
        check_output("err_resp_fire", 128'(bus.master_resp_valid), 128'(1'b1));
        step();
        #1;
        check_output("err_resp_done", 128'(bus.master_resp_valid), 128'(1'b0));

        $display("[TB] full queue");
        bus.master_resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            drive_req(1'b1, 32'h0000_0010);
            #1;
            check_output("full_accept", 128'(bus.master_req_ready), 128'(1'b1));
        end
        step();
        #1;
        check_output("full_stall_ready", 128'(bus.master_req_ready), 128'(1'b0));
        check_output("full_stall_slv", 128'(bus.slave_req_valid), 128'(2'b00));
        step();
        bus.slave_resp_valid  = 2'b01;
        bus.master_resp_ready = 1'b1;
        #1;
        check_output("full_pop_resp", 128'(bus.master_resp_valid), 128'(1'b1));
        check_output("full_pop_ready", 128'(bus.master_req_ready), 128'(1'b0));
        check_output("full_pop_slv", 128'(bus.slave_req_valid), 128'(2'b00));
        step();
        bus.slave_resp_valid  = 2'b00;
        bus.master_resp_ready = 1'b0;
        #1;
        check_output("full_after_ready", 128'(bus.master_req_ready), 128'(1'b1));
        check_output("full_after_slv", 128'(bus.slave_req_valid), 128'(2'b01));
        step();
        drive_req(1'b0, 32'h0);
        bus.slave_resp_valid  = 2'b01;
        bus.master_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #1;
        check_output("full_drain_valid", 128'(bus.master_resp_valid), 128'(1'b0));
        check_output("full_drain_ready", 128'(bus.slave_resp_ready), 128'(2'b00));

        $display("[TB] backpressure");
        bus.slave_resp_valid  = 2'b00;
        bus.master_resp_ready = 1'b0;
        bus.slave_req_ready   = 2'b00;
        bus.master_req_valid  = 1'b1;
        bus.master_req_data   = '{addr: 32'h0000_0100, wdata: 32'h1234_5678, we: 1'b1, be: 4'b0011};
        for (int i = 0; i < 5; i++) begin
            #1;
            check_output("bp_req_ready", 128'(bus.master_req_ready), 128'(1'b0));
            check_output("bp_slv_valid", 128'(bus.slave_req_valid), 128'(2'b01));
            check_output("bp_slv_data", 128'(bus.slave_req_data[0]),
                         128'({32'h0000_0100, 32'h1234_5678, 1'b1, 4'b0011}));
            step();
        end
        bus.slave_req_ready = 2'b01;
        #1;
        check_output("bp_fire", 128'(bus.master_req_ready), 128'(1'b1));
        step();
        drive_req(1'b0, 32'h0);
        bus.slave_resp_valid  = 2'b01;
        bus.master_resp_ready = 1'b1;
        #1;
        check_output("bp_one_entry", 128'(bus.master_resp_valid), 128'(1'b1));
        step();
        #1;
        check_output("bp_only_one", 128'(bus.master_resp_valid), 128'(1'b0));

        $display("[TB] reset mid-flight");
        bus.slave_resp_valid  = 2'b00;
        bus.master_resp_ready = 1'b0;
        bus.slave_req_ready   = 2'b11;
        drive_req(1'b1, 32'h0000_0000);
        step();
        drive_req(1'b1, 32'h1000_0000);
        step();
        drive_req(1'b0, 32'h0);
        bus.slave_resp_valid  = 2'b11;
        bus.master_resp_ready = 1'b1;
        #1;
        check_output("rm_pre_valid", 128'(bus.master_resp_valid), 128'(1'b1));
        check_output("rm_pre_ready", 128'(bus.slave_resp_ready), 128'(2'b01));
        rst_n = 1'b0;
        #1;
        check_output("rm_flush_valid", 128'(bus.master_resp_valid), 128'(1'b0));
        check_output("rm_flush_ready", 128'(bus.slave_resp_ready), 128'(2'b00));
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_output("rm_post_valid", 128'(bus.master_resp_valid), 128'(1'b0));
        check_output("rm_post_ready", 128'(bus.slave_resp_ready), 128'(2'b00));
        step();
        #1;
        check_output("rm_later_valid", 128'(bus.master_resp_valid), 128'(1'b0));
        check_output("rm_later_ready", 128'(bus.slave_resp_ready), 128'(2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
